// File: rtl/oled_spi_pkg.sv
// Shared types and defaults for the OLED SPI receive monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oled_spi_pkg;

  // Level of the dc pin for each byte type.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } rx_state_t;

  // One received byte together with its dc tag.
  typedef struct packed {
    logic       is_data;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/oled_spi_rx_monitor_if.sv
// SPI pins, FIFO read port and status of the receive monitor.
// Latency: n/a (signal bundle).
// Backpressure: rd_valid/rd_ready on the read side; SPI side has none.
// Modports: master = stimulus/consumer side, slave = monitor side.
interface oled_spi_rx_monitor_if;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        oled_dc;
  logic        oled_res_n;
  logic        rd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_is_data;
  logic        overflow;
  logic        frame_err;
  logic [15:0] byte_count;
  logic        clr_status;

  modport master (
    output spi_cs_n, spi_clk, spi_mosi, oled_dc, oled_res_n, rd_ready, clr_status,
    input  rd_valid, rd_data, rd_is_data, overflow, frame_err, byte_count
  );

  modport slave (
    input  spi_cs_n, spi_clk, spi_mosi, oled_dc, oled_res_n, rd_ready, clr_status,
    output rd_valid, rd_data, rd_is_data, overflow, frame_err, byte_count
  );
endinterface

// File: rtl/oled_rx_fifo.sv
// First-word-fall-through FIFO of tagged rx bytes with synchronous flush.
// Latency: a push is visible at o_head the cycle after it is written.
// Backpressure: a push into a full FIFO is refused unless a pop happens in the same cycle.
// Ports: i_push/i_push_dat write, i_pop consume head, i_flush empties, o_head/o_full/o_empty.
module oled_rx_fifo
  import oled_spi_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  rx_entry_t i_push_dat,
  input  logic      i_pop,
  input  logic      i_flush,
  output rx_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  rx_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot being written, so full + pop still accepts.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head reads as zero when empty so the output is clean after reset/flush.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/oled_spi_rx_monitor.sv
// Rebuilds the OLED 4-wire SPI stream into dc-tagged bytes in a FIFO.
// Latency: rd_valid rises SYNC_STAGES+2 clk after the 8th sclk rise at the pins (FIFO empty).
// Backpressure: rd_ready stalls the head; a byte arriving while full is dropped and flagged.
// Ports: clk, rst_n (async, active-low), rx_if (slave): SPI/panel pins in,
//        rd_valid/rd_data/rd_is_data/rd_ready read port, overflow/frame_err/byte_count status,
//        clr_status pulse clears the sticky flags.
module oled_spi_rx_monitor
  import oled_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  oled_spi_rx_monitor_if.slave rx_if
);

  // Synchroniser bit layout and the idle level of each pin.
  localparam int         P_CS   = 4;
  localparam int         P_SCLK = 3;
  localparam int         P_MOSI = 2;
  localparam int         P_DC   = 1;
  localparam int         P_RES  = 0;
  localparam logic [4:0] SYNC_RST = 5'b10001;

  logic [4:0] w_pins;
  logic [4:0] r_sync [SYNC_STAGES];
  logic [4:0] w_sync;
  logic       w_cs_n_s;
  logic       w_sclk_s;
  logic       w_mosi_s;
  logic       w_dc_s;
  logic       w_res_n_s;
  logic       r_sclk_d;
  logic       w_sclk_rise;

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic       w_shift_en;
  logic       w_clear_rx;
  logic       w_flush;
  logic       w_frame_evt;

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_push_vld;
  logic       r_push_dc;

  rx_entry_t  w_push_dat;
  rx_entry_t  w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_accept;
  logic       w_drop;

  logic        r_overflow;
  logic        r_frame_err;
  logic [15:0] r_byte_count;

  // ---------------- input synchroniser ----------------
  assign w_pins = {rx_if.spi_cs_n, rx_if.spi_clk, rx_if.spi_mosi, rx_if.oled_dc, rx_if.oled_res_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_cs_n_s  = w_sync[P_CS];
  assign w_sclk_s  = w_sync[P_SCLK];
  assign w_mosi_s  = w_sync[P_MOSI];
  assign w_dc_s    = w_sync[P_DC];
  assign w_res_n_s = w_sync[P_RES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sclk_d <= 1'b0;
    else        r_sclk_d <= w_sclk_s;
  end

  assign w_sclk_rise = w_sclk_s && !r_sclk_d;

  // ---------------- rx FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_res_n_s) begin
      w_state_nxt = HOLD;
    end else begin
      case (r_state)
        IDLE:    if (!w_cs_n_s) w_state_nxt = ACTIVE;
        ACTIVE:  if (w_cs_n_s)  w_state_nxt = IDLE;
        HOLD:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_en  = 1'b0;
    w_clear_rx  = 1'b0;
    w_flush     = 1'b0;
    w_frame_evt = 1'b0;
    case (r_state)
      IDLE: w_clear_rx = 1'b1;
      ACTIVE: begin
        // Panel reset takes priority; the HOLD state does the clearing next cycle.
        if (w_res_n_s) begin
          if (w_cs_n_s) begin
            w_frame_evt = (r_bit_cnt != 3'd0);
            w_clear_rx  = 1'b1;
          end else begin
            w_shift_en = w_sclk_rise;
          end
        end
      end
      HOLD: begin
        w_clear_rx = 1'b1;
        w_flush    = 1'b1;
      end
      default: w_clear_rx = 1'b1;
    endcase
  end

  // ---------------- shifter ----------------
  // The completed byte stays in r_shift for the push cycle; the next sclk
  // rise is at least 4 clk away so it cannot be overwritten in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_push_vld <= 1'b0;
      r_push_dc  <= 1'b0;
    end else begin
      r_push_vld <= 1'b0;
      if (w_clear_rx) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[6:0], w_mosi_s};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_push_vld <= 1'b1;
          r_push_dc  <= w_dc_s;
        end
      end
    end
  end

  // ---------------- FIFO ----------------
  assign w_push_dat.is_data = r_push_dc;
  assign w_push_dat.data    = r_shift;
  assign w_pop    = !w_empty && rx_if.rd_ready;
  assign w_accept = r_push_vld && !w_flush && (!w_full || w_pop);
  assign w_drop   = r_push_vld && !w_flush && w_full && !w_pop;

  oled_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_push_vld),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // ---------------- status ----------------
  // A new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_count <= '0;
    end else begin
      if (w_drop)                r_overflow <= 1'b1;
      else if (rx_if.clr_status) r_overflow <= 1'b0;
      if (w_frame_evt)           r_frame_err <= 1'b1;
      else if (rx_if.clr_status) r_frame_err <= 1'b0;
      if (w_accept)              r_byte_count <= r_byte_count + 16'd1;
    end
  end

  assign rx_if.rd_valid   = !w_empty;
  assign rx_if.rd_data    = w_head.data;
  assign rx_if.rd_is_data = w_head.is_data;
  assign rx_if.overflow   = r_overflow;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.byte_count = r_byte_count;

endmodule
